apb_slave_mem: RTL and testbench

//   APB completer (slave) fronting a word-addressed register memory; responds to the team's APB

---
 rtl/apb_slave_mem.sv | 151 +++++++++++++++
 tb/tb_apb_slave_mem.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB completer in front of a word-addressed register memory.
// Programmable wait states, byte strobes and a decode-error response.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int LANES  = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-3:0] DEPTH_W = (ADDR_WIDTH-2)'(MEM_DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic                    err_q, err_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [LANES-1:0]        strb_q, strb_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic                    mem_we_s;
  logic                    setup_s, access_s, dec_err_s;
  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

  assign setup_s   = PSEL & ~PENABLE;
  assign access_s  = PSEL & PENABLE;
  assign dec_err_s = (PADDR[1:0] != 2'b00) || (PADDR[ADDR_WIDTH-1:2] >= DEPTH_W);

  // Next-state, request latch, write enable and registered response computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    err_d     = err_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    mem_we_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (setup_s) begin
          write_d = PWRITE;
          err_d   = dec_err_s;
          idx_d   = PADDR[IDX_W+1:2];
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!access_s) begin
          state_d = S_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d  = S_IDLE;
        mem_we_s = access_s & write_q & ~err_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Response is prepared one edge early so PREADY/PRDATA come straight from flops.
    if (state_d == S_RESP) begin
      pready_d  = 1'b1;
      pslverr_d = err_d;
      prdata_d  = (!write_d && !err_d) ? mem_q[idx_d] : '0;
    end else begin
      pready_d  = 1'b0;
    end
  end

  // Control FSM and output registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  // Storage array; a write lands on the edge that completes the transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int w = 0; w < MEM_DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else if (mem_we_s) begin
      for (int l = 0; l < LANES; l++) begin
        if (strb_q[l]) begin
          mem_q[idx_q][8*l +: 8] <= wdata_q[8*l +: 8];
        end
      end
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: three instances with 0, 2 and 3 wait states
// share one APB bus, each selected by its own PSEL bit.
module tb_apb_slave_mem;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic [2:0]  psel = 3'b000;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = 32'd0;
  logic [31:0] pwdata = 32'd0;
  logic [3:0]  pstrb = 4'd0;
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;
  exp_t sb_q[$];

  always #5 pclk = ~pclk;

  apb_slave_mem #(.WAIT_STATES(0)) u_ws0 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_slave_mem #(.WAIT_STATES(2)) u_ws2 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_slave_mem #(.WAIT_STATES(3)) u_ws3 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_quiet(input string tag, input int d);
    check_eq({tag, "_pready"}, 32'(pready[d]), 32'd0);
    check_eq({tag, "_pslverr"}, 32'(pslverr[d]), 32'd0);
    check_eq({tag, "_prdata"}, prdata[d], 32'd0);
  endtask

  task automatic bus_idle();
    psel    = 3'b000;
    penable = 1'b0;
    @(negedge pclk);
  endtask

  // Full transfer starting at a negedge: setup, access until PREADY, then one IDLE cycle.
  task automatic apb_xfer(input string tag, input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input logic exp_err, input logic [31:0] exp_rdata, input int exp_waits);
    exp_t e;
    int   waits;
    logic done;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err, waits: exp_waits});
    psel    = 3'b000;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    @(negedge pclk);
    penable = 1'b1;
    paddr   = $urandom;
    pwdata  = $urandom;
    pstrb   = 4'($urandom);
    waits   = 0;
    done    = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (pready[d]) begin
        done = 1'b1;
      end else begin
        waits++;
        @(negedge pclk);
      end
    end
    e = sb_q.pop_front();
    check_eq({tag, "_timeout"}, 32'(done), 32'd1);
    if (done) begin
      check_eq({tag, "_prdata"}, prdata[d], e.rdata);
      check_eq({tag, "_pslverr"}, 32'(pslverr[d]), 32'(e.err));
      check_eq({tag, "_waits"}, 32'(waits), 32'(e.waits));
    end
    @(negedge pclk);
    check_quiet({tag, "_after"}, d);
  endtask

  initial begin
    repeat (3) @(negedge pclk);
    for (int d = 0; d < 3; d++) check_quiet("reset", d);
    presetn = 1'b1;
    @(negedge pclk);

    // Zero wait states: full write, partial strobes, no-op strobes, back-to-back
    apb_xfer("w0_full", 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 0);
    apb_xfer("r0_full", 0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 0);
    apb_xfer("w0_strb", 0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0, 32'h0, 0);
    apb_xfer("r0_strb", 0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, 0);
    apb_xfer("w0_nostrb", 0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0, 0);
    apb_xfer("r0_nostrb", 0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, 0);
    apb_xfer("w0_oor", 0, 1'b1, 32'h100, 32'h55555555, 4'hF, 1'b1, 32'h0, 0);
    apb_xfer("w0_misal", 0, 1'b1, 32'h13, 32'h66666666, 4'hF, 1'b1, 32'h0, 0);
    apb_xfer("r0_oor", 0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'h0, 0);
    apb_xfer("r0_keep", 0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, 0);
    apb_xfer("w0_last", 0, 1'b1, 32'hFC, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0, 0);
    apb_xfer("r0_last", 0, 1'b0, 32'hFC, 32'h0, 4'h0, 1'b0, 32'hA5A5A5A5, 0);
    bus_idle();

    // Zero wait states: master abandons during the response cycle, no write
    psel    = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h30;
    pwdata  = 32'h0BADF00D;
    pstrb   = 4'hF;
    @(negedge pclk);
    psel    = 3'b000;
    @(negedge pclk);
    check_quiet("abort_resp", 0);
    apb_xfer("r0_abort", 0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 32'h0, 0);
    bus_idle();

    // Two wait states
    apb_xfer("r2_init", 1, 1'b0, 32'h04, 32'h0, 4'h0, 1'b0, 32'h0, 2);
    apb_xfer("w2", 1, 1'b1, 32'h04, 32'h12345678, 4'hF, 1'b0, 32'h0, 2);
    apb_xfer("r2", 1, 1'b0, 32'h04, 32'h0, 4'h0, 1'b0, 32'h12345678, 2);
    bus_idle();

    // Three wait states: PSEL drops in the second wait cycle of a write
    apb_xfer("w3_seed", 2, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 3);
    psel    = 3'b100;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h20;
    pwdata  = 32'hCAFEF00D;
    pstrb   = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    check_eq("abort_w1_pready", 32'(pready[2]), 32'd0);
    @(negedge pclk);
    psel    = 3'b000;
    penable = 1'b0;
    check_eq("abort_w2_pready", 32'(pready[2]), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge pclk);
      check_eq("abort_after_pready", 32'(pready[2]), 32'd0);
    end
    apb_xfer("r3_abort", 2, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h0, 3);
    apb_xfer("r3_seed", 2, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 3);
    bus_idle();

    // Reset asserted between edges in the middle of a wait
    psel    = 3'b100;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h10;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    #2 presetn = 1'b0;
    #1 check_quiet("rst_mid", 2);
    psel    = 3'b000;
    penable = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    apb_xfer("r3_rst", 2, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0, 3);
    apb_xfer("r0_rst", 0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0, 0);
    bus_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
